// File: rtl/ex_mem_register.sv
// ---------------------------------------------------------------------------
// ex_mem_register
//
// Purpose:
//   Pipeline register between the Execute and Memory stages. It captures the
//   ALU result, the store data, the destination register index and the
//   control bundle at the end of Execute. It also owns the architectural
//   flag register {C,N,Z}. Execute computes the flags but does not store them.
//   The hazard unit can hold every register (stall) or turn the captured
//   instruction into a bubble (flush). Flush wins over stall.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            asynchronous, active-low reset; clears every register
//   stall          hold every register, including the flags
//   flush          replace the captured instruction with a bubble
//   in_valid       Execute holds a real instruction this cycle
//   controlSignals control bundle from Execute        [CTRL_W]
//   aluResult      ALU output                         [DATA_W]
//   readData2      store data / second operand        [DATA_W]
//   writeReg       destination register index         [REG_W]
//   aluFlags       ALU flags {C,N,Z}                  [3]
//   flagEn         per-bit flag update enable {C,N,Z} [3]
//   setC / clrC    force carry to 1 / 0 (clrC wins)
//   out_valid      Memory stage holds a real instruction
//   ctrlOut        registered control bundle          [CTRL_W]
//   aluOut         registered ALU result              [DATA_W]
//   dataOut        registered store data              [DATA_W]
//   regOut         registered destination index       [REG_W]
//   flag           current flag register {C,N,Z}      [3]
// ---------------------------------------------------------------------------
module ex_mem_register #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 11,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] controlSignals,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] readData2,
  input  logic [REG_W-1:0]  writeReg,
  input  logic [2:0]        aluFlags,
  input  logic [2:0]        flagEn,
  input  logic              setC,
  input  logic              clrC,
  output logic              out_valid,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic [DATA_W-1:0] aluOut,
  output logic [DATA_W-1:0] dataOut,
  output logic [REG_W-1:0]  regOut,
  output logic [2:0]        flag
);

  // Bit positions inside the flag register.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] alu_q,   alu_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [REG_W-1:0]  reg_q,   reg_d;
  logic [2:0]        flag_q,  flag_d;

  // A real instruction retires its flag effects only when it moves forward.
  logic accept;
  assign accept = in_valid & ~stall & ~flush;

  // -------------------------------------------------------------------------
  // Pipeline payload
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    data_d  = data_q;
    reg_d   = reg_q;

    if (flush) begin
      // The bubble is all zeros. This check comes first so that it also
      // overrides a concurrent stall.
      valid_d = 1'b0;
      ctrl_d  = '0;
      alu_d   = '0;
      data_d  = '0;
      reg_d   = '0;
    end else if (!stall) begin
      valid_d = in_valid;
      // The data fields load even for a bubble. The control bundle is zeroed,
      // so the bubble cannot write memory or the register file downstream.
      ctrl_d  = in_valid ? controlSignals : '0;
      alu_d   = aluResult;
      data_d  = readData2;
      reg_d   = writeReg;
    end
  end

  // -------------------------------------------------------------------------
  // Flag register
  // -------------------------------------------------------------------------
  always_comb begin
    flag_d = flag_q;
    if (accept) begin
      flag_d[FLAG_Z] = flagEn[FLAG_Z] ? aluFlags[FLAG_Z] : flag_q[FLAG_Z];
      flag_d[FLAG_N] = flagEn[FLAG_N] ? aluFlags[FLAG_N] : flag_q[FLAG_N];
      // Explicit carry instructions take precedence over the ALU carry.
      // CLRC wins over SETC if decode ever raises both.
      if (clrC) begin
        flag_d[FLAG_C] = 1'b0;
      end else if (setC) begin
        flag_d[FLAG_C] = 1'b1;
      end else begin
        flag_d[FLAG_C] = flagEn[FLAG_C] ? aluFlags[FLAG_C] : flag_q[FLAG_C];
      end
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      data_q  <= '0;
      reg_q   <= '0;
      flag_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      data_q  <= data_d;
      reg_q   <= reg_d;
      flag_q  <= flag_d;
    end
  end

  assign out_valid = valid_q;
  assign ctrlOut   = ctrl_q;
  assign aluOut    = alu_q;
  assign dataOut   = data_q;
  assign regOut    = reg_q;
  // Registered on purpose: Execute sees the flags of the previous accepted
  // instruction, with no bypass path.
  assign flag      = flag_q;

endmodule

// File: tb/tb_ex_mem_register.sv
module tb_ex_mem_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, in_valid;
  logic [10:0] controlSignals;
  logic [15:0] aluResult, readData2;
  logic [2:0]  writeReg, aluFlags, flagEn;
  logic        setC, clrC;
  logic        out_valid;
  logic [10:0] ctrlOut;
  logic [15:0] aluOut, dataOut;
  logic [2:0]  regOut, flag;

  int checks = 0;
  int errors = 0;

  ex_mem_register #(.DATA_W(16), .CTRL_W(11), .REG_W(3)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .controlSignals(controlSignals), .aluResult(aluResult),
    .readData2(readData2), .writeReg(writeReg), .aluFlags(aluFlags),
    .flagEn(flagEn), .setC(setC), .clrC(clrC), .out_valid(out_valid),
    .ctrlOut(ctrlOut), .aluOut(aluOut), .dataOut(dataOut), .regOut(regOut),
    .flag(flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, in_valid;
    logic [10:0] ctrl;
    logic [15:0] alu, data;
    logic [2:0]  wreg, aflags, fen;
    logic        setc, clrc;
    logic        e_valid;
    logic [10:0] e_ctrl;
    logic [15:0] e_alu, e_data;
    logic [2:0]  e_reg, e_flag;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [10:0] ec,
                           input logic [15:0] ea, input logic [15:0] ed,
                           input logic [2:0] er, input logic [2:0] ef);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".ctrlOut"},   32'(ctrlOut),   32'(ec));
    check({tag, ".aluOut"},    32'(aluOut),    32'(ea));
    check({tag, ".dataOut"},   32'(dataOut),   32'(ed));
    check({tag, ".regOut"},    32'(regOut),    32'(er));
    check({tag, ".flag"},      32'(flag),      32'(ef));
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic [10:0] c,
                       input logic [15:0] a, input logic [15:0] d, input logic [2:0] w,
                       input logic [2:0] af, input logic [2:0] fe, input logic sc,
                       input logic cc);
    stall = st; flush = fl; in_valid = v; controlSignals = c; aluResult = a;
    readData2 = d; writeReg = w; aluFlags = af; flagEn = fe; setC = sc; clrC = cc;
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // stall flush v  ctrl    alu       data      reg   afl     fen     sC    cC  | valid ctrl alu data reg flag
    vecs[0]  = '{0,0,1, 11'h405,16'h0000,16'hBEEF,3'd5,3'b000,3'b000,0,0, 1,11'h405,16'h0000,16'hBEEF,3'd5,3'b000};
    vecs[1]  = '{0,0,0, 11'h405,16'h0000,16'hBEEF,3'd5,3'b111,3'b111,0,0, 0,11'h000,16'h0000,16'hBEEF,3'd5,3'b000};
    vecs[2]  = '{0,0,1, 11'h012,16'h00AA,16'h0001,3'd2,3'b000,3'b000,0,0, 1,11'h012,16'h00AA,16'h0001,3'd2,3'b000};
    vecs[3]  = '{1,0,1, 11'h7FF,16'h5555,16'hFFFF,3'd7,3'b111,3'b111,0,0, 1,11'h012,16'h00AA,16'h0001,3'd2,3'b000};
    vecs[4]  = '{1,0,1, 11'h7FF,16'h5555,16'hFFFF,3'd7,3'b111,3'b111,1,0, 1,11'h012,16'h00AA,16'h0001,3'd2,3'b000};
    vecs[5]  = '{1,0,1, 11'h7FF,16'h5555,16'hFFFF,3'd7,3'b111,3'b111,0,0, 1,11'h012,16'h00AA,16'h0001,3'd2,3'b000};
    vecs[6]  = '{0,0,1, 11'h7FF,16'h5555,16'hFFFF,3'd7,3'b111,3'b000,0,0, 1,11'h7FF,16'h5555,16'hFFFF,3'd7,3'b000};
    vecs[7]  = '{1,1,1, 11'h7FF,16'h1111,16'h2222,3'd3,3'b111,3'b111,1,0, 0,11'h000,16'h0000,16'h0000,3'd0,3'b000};
    vecs[8]  = '{0,0,1, 11'h001,16'h0010,16'h0020,3'd1,3'b111,3'b001,0,0, 1,11'h001,16'h0010,16'h0020,3'd1,3'b001};
    vecs[9]  = '{0,0,1, 11'h002,16'h0011,16'h0021,3'd2,3'b010,3'b110,0,0, 1,11'h002,16'h0011,16'h0021,3'd2,3'b011};
    vecs[10] = '{0,0,1, 11'h003,16'h0012,16'h0022,3'd3,3'b100,3'b100,1,1, 1,11'h003,16'h0012,16'h0022,3'd3,3'b011};
    vecs[11] = '{0,0,1, 11'h004,16'h0013,16'h0023,3'd4,3'b000,3'b000,1,0, 1,11'h004,16'h0013,16'h0023,3'd4,3'b111};
    vecs[12] = '{0,0,1, 11'h005,16'h0014,16'h0024,3'd5,3'b000,3'b000,0,1, 1,11'h005,16'h0014,16'h0024,3'd5,3'b011};
    vecs[13] = '{0,0,0, 11'h003,16'h0044,16'h0055,3'd6,3'b111,3'b111,1,0, 0,11'h000,16'h0044,16'h0055,3'd6,3'b011};
    vecs[14] = '{1,0,1, 11'h7FF,16'hFFFF,16'hFFFF,3'd7,3'b111,3'b111,1,0, 0,11'h000,16'h0044,16'h0055,3'd6,3'b011};
    vecs[15] = '{0,1,1, 11'h7FF,16'hFFFF,16'hFFFF,3'd7,3'b111,3'b111,1,0, 0,11'h000,16'h0000,16'h0000,3'd0,3'b011};
    vecs[16] = '{0,0,1, 11'h006,16'h0015,16'h0025,3'd0,3'b000,3'b111,0,0, 1,11'h006,16'h0015,16'h0025,3'd0,3'b000};

    // Reset holds everything at zero while clocks run with random inputs.
    rst = 1'b0;
    drive(1'($urandom), 1'($urandom), 1'($urandom), 11'($urandom), 16'($urandom),
          16'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 11'h0, 16'h0, 16'h0, 3'd0, 3'b000);
    $display("txn reset: valid=%0b alu=%h flag=%b", out_valid, aluOut, flag);

    // First capture on the first edge after release.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 11'h001, 16'h1234, 16'h0000, 3'd0, 3'b000, 3'b000, 0, 0);
    step();
    check_all("release", 1'b1, 11'h001, 16'h1234, 16'h0000, 3'd0, 3'b000);
    $display("txn release: valid=%0b alu=%h flag=%b", out_valid, aluOut, flag);

    // Table-driven vectors, one edge each.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].flush, vecs[i].in_valid, vecs[i].ctrl, vecs[i].alu,
            vecs[i].data, vecs[i].wreg, vecs[i].aflags, vecs[i].fen, vecs[i].setc, vecs[i].clrc);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ctrl, vecs[i].e_alu,
                vecs[i].e_data, vecs[i].e_reg, vecs[i].e_flag);
      $display("txn vec%0d: st=%0b fl=%0b v=%0b -> valid=%0b ctrl=%h alu=%h data=%h reg=%0d flag=%b",
               i, vecs[i].stall, vecs[i].flush, vecs[i].in_valid, out_valid, ctrlOut,
               aluOut, dataOut, regOut, flag);
    end

    // Load nonzero state, then assert reset mid-stall between edges.
    @(negedge clk);
    drive(0, 0, 1, 11'h0AB, 16'hCAFE, 16'hF00D, 3'd4, 3'b101, 3'b111, 0, 0);
    step();
    check_all("preload", 1'b1, 11'h0AB, 16'hCAFE, 16'hF00D, 3'd4, 3'b101);
    $display("txn preload: alu=%h flag=%b", aluOut, flag);
    @(negedge clk);
    stall = 1'b1;
    step();
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 11'h0, 16'h0, 16'h0, 3'd0, 3'b000);
    $display("txn async_rst: valid=%0b alu=%h flag=%b", out_valid, aluOut, flag);

    // Release with stall active: the first edge holds the zeroed state.
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 1, 11'h7FF, 16'hABCD, 16'h1111, 3'd7, 3'b111, 3'b111, 1, 0);
    step();
    check_all("rel_stall", 1'b0, 11'h0, 16'h0, 16'h0, 3'd0, 3'b000);
    $display("txn rel_stall: valid=%0b alu=%h flag=%b", out_valid, aluOut, flag);

    @(negedge clk);
    drive(0, 1, 1, 11'h7FF, 16'hABCD, 16'h1111, 3'd7, 3'b111, 3'b111, 1, 0);
    step();
    check_all("flush_only", 1'b0, 11'h0, 16'h0, 16'h0, 3'd0, 3'b000);
    $display("txn flush_only: valid=%0b alu=%h flag=%b", out_valid, aluOut, flag);

    // Back-to-back accepts overwrite each other.
    @(negedge clk);
    drive(0, 0, 1, 11'h100, 16'h9999, 16'h8888, 3'd1, 3'b010, 3'b111, 0, 0);
    step();
    check_all("b2b_a", 1'b1, 11'h100, 16'h9999, 16'h8888, 3'd1, 3'b010);
    $display("txn b2b_a: alu=%h flag=%b", aluOut, flag);
    @(negedge clk);
    drive(0, 0, 1, 11'h200, 16'h7777, 16'h6666, 3'd2, 3'b001, 3'b011, 0, 0);
    step();
    check_all("b2b_b", 1'b1, 11'h200, 16'h7777, 16'h6666, 3'd2, 3'b001);
    $display("txn b2b_b: alu=%h flag=%b", aluOut, flag);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
